sms_sample_pulse_receiver: RTL



---
 rtl/sms_sample_rx_pkg.sv | 22 ++
 rtl/sms_sample_rx_filter.sv | 52 +++++
 rtl/sms_sample_pulse_receiver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sms_sample_rx_pkg.sv
// Shared types and defaults for the SDTRL sample-pulse receiver.
// FSM state encoding, default parameter values and the width-counter sizing helper.
package sms_sample_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LONG,
    ST_GUARD
  } rx_state_t;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_MIN_W  = 3;
  localparam int DEF_MAX_W  = 6;
  localparam int DEF_GUARD  = 2;

  // Counter must hold MAX_W+1 so "would exceed" is representable without wrapping.
  function automatic int width_bits(input int max_w);
    return $clog2(max_w + 2);
  endfunction

endpackage

// File: rtl/sms_sample_rx_filter.sv
// Input stage of the sample-pulse receiver: registers d, optionally majority-filters it,
// and produces the level s and a one-cycle rise. Optional filter: SAMPLE_RX_GLITCH_FILTER_EN.
module sms_sample_rx_filter (
  input  logic x,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise
);

  logic s_reg;
  logic s_prev_reg;
  logic armed_reg;
  logic s_next;

`ifdef SAMPLE_RX_GLITCH_FILTER_EN
  // hist_reg[0] is d's register; s follows the 2-of-3 vote over the registered samples.
  logic [2:0] hist_reg;

  always_ff @(posedge x) begin
    if (reset) begin
      hist_reg <= '0;
    end else begin
      hist_reg <= {hist_reg[1:0], d};
    end
  end

  assign s_next = (hist_reg[0] & hist_reg[1]) |
                  (hist_reg[0] & hist_reg[2]) |
                  (hist_reg[1] & hist_reg[2]);
`else
  assign s_next = d;
`endif

  // armed_reg stays low until d has been seen low once, so a pulse already
  // high when reset is released cannot produce a rise.
  always_ff @(posedge x) begin
    if (reset) begin
      s_reg      <= 1'b0;
      s_prev_reg <= 1'b0;
      armed_reg  <= 1'b0;
    end else begin
      s_reg      <= s_next;
      s_prev_reg <= s_reg;
      armed_reg  <= armed_reg | ~d;
    end
  end

  assign s    = s_reg;
  assign rise = s_reg & ~s_prev_reg & armed_reg;

endmodule

// File: rtl/sms_sample_pulse_receiver.sv
// Receiving end of the SDTRL sample-pulse path: measures pulse width, latches data on
// valid pulses, flags short/long pulses. Optional input filter: SAMPLE_RX_GLITCH_FILTER_EN.
module sms_sample_pulse_receiver
  import sms_sample_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MIN_W  = DEF_MIN_W,
  parameter int MAX_W  = DEF_MAX_W,
  parameter int GUARD  = DEF_GUARD
) (
  input  logic              x,
  input  logic              reset,
  input  logic              d,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              strobe,
  output logic              err_short,
  output logic              err_long,
  output logic              busy
);

  localparam int WW = width_bits(MAX_W);
  localparam int GW = $clog2(GUARD + 1);
  localparam logic [WW-1:0] MIN_V   = WW'(MIN_W);
  localparam logic [WW-1:0] MAX_V   = WW'(MAX_W);
  localparam logic [GW-1:0] GUARD_V = GW'(GUARD);

  logic s;
  logic rise;

  rx_state_t         state_reg,  state_next;
  logic [WW-1:0]     width_reg,  width_next;
  logic [WW-1:0]     width_inc;
  logic [GW-1:0]     guard_reg,  guard_next;
  logic [DATA_W-1:0] shadow_reg, shadow_next;
  logic [DATA_W-1:0] q_reg,      q_next;
  logic              strobe_reg, strobe_next;
  logic              short_reg,  short_next;
  logic              long_reg,   long_next;

  sms_sample_rx_filter u_filter (
    .x    (x),
    .reset(reset),
    .d    (d),
    .s    (s),
    .rise (rise)
  );

  always_ff @(posedge x) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      width_reg  <= '0;
      guard_reg  <= '0;
      shadow_reg <= '0;
      q_reg      <= '0;
      strobe_reg <= 1'b0;
      short_reg  <= 1'b0;
      long_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      width_reg  <= width_next;
      guard_reg  <= guard_next;
      shadow_reg <= shadow_next;
      q_reg      <= q_next;
      strobe_reg <= strobe_next;
      short_reg  <= short_next;
      long_reg   <= long_next;
    end
  end

  assign width_inc = (width_reg == '1) ? width_reg : width_reg + WW'(1);

  always_comb begin
    state_next  = state_reg;
    width_next  = width_reg;
    guard_next  = guard_reg;
    shadow_next = shadow_reg;
    q_next      = q_reg;
    strobe_next = 1'b0;
    short_next  = 1'b0;
    long_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_MEASURE;
          width_next = WW'(1);
          if (MIN_W == 1) shadow_next = data;
        end
      end
      ST_MEASURE: begin
        if (s) begin
          if (width_reg == MAX_V) begin
            long_next  = 1'b1;
            state_next = ST_LONG;
          end else begin
            width_next = width_inc;
            if (width_inc == MIN_V) shadow_next = data;
          end
        end else begin
          if (width_reg < MIN_V) begin
            short_next = 1'b1;
          end else begin
            q_next      = shadow_reg;
            strobe_next = 1'b1;
          end
          state_next = ST_GUARD;
          guard_next = GUARD_V;
        end
      end
      ST_LONG: begin
        if (!s) begin
          state_next = ST_GUARD;
          guard_next = GUARD_V;
        end
      end
      ST_GUARD: begin
        if (guard_reg <= GW'(1)) begin
          state_next = ST_IDLE;
          guard_next = '0;
        end else begin
          guard_next = guard_reg - GW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != ST_IDLE);
    q         = q_reg;
    strobe    = strobe_reg;
    err_short = short_reg;
    err_long  = long_reg;
  end

endmodule
